fpu_half_sequencer: RTL

//  Command loader and issue sequencer for the half-precision FPU in the user project.
//  - Load: collects a command program from the UART receiver byte stream into a local buffer.
//  - Execute: issues each command to the FPU in order, then holds each result on the output bus

---
 rtl/fpu_half_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fpu_half_sequencer.sv
// Loads a command program from a UART byte stream, then issues each command to the
// half-precision FPU in order and holds every result on the output bus.
module fpu_half_sequencer #(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_TIMEOUT = 100000
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        fpu_valid_o,
    input  logic        fpu_ready_i,
    output logic [4:0]  fpu_op_o,
    output logic [2:0]  fpu_rm_o,
    output logic [15:0] fpu_a_o,
    output logic [15:0] fpu_b_o,
    output logic [15:0] fpu_c_o,
    input  logic        fpu_done_i,
    input  logic [15:0] fpu_result_i,
    input  logic [4:0]  fpu_flags_i,
    output logic [15:0] result_o,
    output logic [4:0]  flags_o,
    output logic        prog_ready_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, HOLD, DONE} state_t;

    state_t          state_reg;
    logic [7:0]      n_reg;
    logic [IW-1:0]   idx_reg;
    logic [IW-1:0]   entry_reg;
    logic [2:0]      lane_reg;
    logic [HW-1:0]   hold_cnt_reg;
    logic [GW-1:0]   gap_cnt_reg;

    logic            wr_en;
    logic            last_byte;
    logic            hold_done;
    logic            last_cmd;
    logic [IW-1:0]   rd_addr;
    logic [55:0]     rd_bus;

    assign wr_en     = (state_reg == LOAD) && rx_valid;
    assign last_byte = wr_en && (lane_reg == 3'd6) && (8'(entry_reg) == n_reg - 8'd1);
    assign hold_done = (state_reg == HOLD) && (hold_cnt_reg == HW'(HOLD_CYCLES - 1));
    assign last_cmd  = (8'(idx_reg) == n_reg - 8'd1);
    // Read address runs one step ahead on HOLD->ISSUE so the next entry is ready on entry.
    assign rd_addr   = (hold_done && !last_cmd) ? idx_reg + IW'(1) : idx_reg;

    // One byte-wide buffer per frame byte position; lane 0 is {op,rm}, lane 6 is C[7:0].
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;
            always_ff @(posedge clock) begin
                if (wr_en && lane_reg == 3'(gi))
                    mem[entry_reg] <= rx_byte;
                if (wr_en && lane_reg == 3'(gi) && entry_reg == rd_addr)
                    rd_q <= rx_byte;
                else
                    rd_q <= mem[rd_addr];
            end
            assign rd_bus[(6-gi)*8 +: 8] = rd_q;
        end
    endgenerate

    assign fpu_op_o = fpu_valid_o ? rd_bus[55:51] : 5'd0;
    assign fpu_rm_o = fpu_valid_o ? rd_bus[50:48] : 3'd0;
    assign fpu_a_o  = fpu_valid_o ? rd_bus[47:32] : 16'd0;
    assign fpu_b_o  = fpu_valid_o ? rd_bus[31:16] : 16'd0;
    assign fpu_c_o  = fpu_valid_o ? rd_bus[15:0]  : 16'd0;
    assign busy_o   = (state_reg == ISSUE) || (state_reg == WAIT) || (state_reg == HOLD);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_reg    <= IDLE;
            n_reg        <= 8'd0;
            idx_reg      <= '0;
            entry_reg    <= '0;
            lane_reg     <= 3'd0;
            hold_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            fpu_valid_o  <= 1'b0;
            result_o     <= 16'd0;
            flags_o      <= 5'd0;
            prog_ready_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (rx_valid) begin
                        if (rx_byte != 8'd0 && rx_byte <= 8'(DEPTH)) begin
                            n_reg        <= rx_byte;
                            err_o        <= 1'b0;
                            prog_ready_o <= 1'b0;
                            idx_reg      <= '0;
                            entry_reg    <= '0;
                            lane_reg     <= 3'd0;
                            gap_cnt_reg  <= '0;
                            state_reg    <= LOAD;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (rx_valid) begin
                        gap_cnt_reg <= '0;
                        if (last_byte) begin
                            prog_ready_o <= 1'b1;
                            fpu_valid_o  <= 1'b1;
                            state_reg    <= ISSUE;
                        end else if (lane_reg == 3'd6) begin
                            lane_reg  <= 3'd0;
                            entry_reg <= entry_reg + IW'(1);
                        end else begin
                            lane_reg <= lane_reg + 3'd1;
                        end
                    end else if (gap_cnt_reg == GW'(GAP_TIMEOUT - 1)) begin
                        err_o     <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end
                ISSUE: begin
                    if (fpu_ready_i) begin
                        fpu_valid_o <= 1'b0;
                        state_reg   <= WAIT;
                    end
                end
                WAIT: begin
                    if (fpu_done_i) begin
                        result_o     <= fpu_result_i;
                        flags_o      <= fpu_flags_i;
                        hold_cnt_reg <= '0;
                        state_reg    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        if (last_cmd) begin
                            state_reg <= DONE;
                        end else begin
                            idx_reg     <= idx_reg + IW'(1);
                            fpu_valid_o <= 1'b1;
                            state_reg   <= ISSUE;
                        end
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // Bytes arriving while executing are dropped and flagged.
            if (rx_valid && (state_reg == ISSUE || state_reg == WAIT || state_reg == HOLD))
                err_o <= 1'b1;
        end
    end
endmodule
